// File: rtl/frame_sync_controller.sv
// frame_sync_controller
// Serial frame synchroniser. Hunts for SYNC_PATTERN in a serial bit stream,
// confirms it at the frame period, flywheels through isolated sync errors while
// locked, and deserialises the payload into DATA_W words behind a single
// valid/ready holding register.
// Optional feature: define FSYNC_STATS_EN to add the frame_cnt / slip_cnt
// statistics outputs. With the macro undefined those ports do not exist.
module frame_sync_controller #(
  parameter int                  SYNC_LEN     = 6,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 6'b110110,
  parameter int                  FRAME_LEN    = 16,
  parameter int                  DATA_W       = 8,
  parameter int                  LOCK_CNT     = 2,
  parameter int                  MISS_CNT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked,
  output logic              sync_pulse,
  output logic              frame_err,
`ifdef FSYNC_STATS_EN
  output logic [15:0]       frame_cnt,
  output logic [7:0]        slip_cnt,
`endif
  output logic              overflow
);

  // Counter widths
  localparam int PW = $clog2(FRAME_LEN + SYNC_LEN);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_CNT + 1);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // FSM encoding
  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Frame geometry: payload occupies pos 0..FRAME_LEN-1, the sync word follows,
  // and its last bit lands on CHECK_POS.
  localparam logic [PW-1:0] CHECK_POS   = PW'(FRAME_LEN + SYNC_LEN - 1);
  localparam logic [PW-1:0] PAYLOAD_END = PW'(FRAME_LEN);
  localparam logic [GW-1:0] GOOD_ONE    = GW'(1);
  localparam logic [GW-1:0] LOCK_LAST   = GW'(LOCK_CNT - 1);
  localparam logic [MW-1:0] MISS_LAST   = MW'(MISS_CNT - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_W - 1);

  // Registered state
  logic [1:0]          state_q, state_d;
  logic [SYNC_LEN-2:0] win_q, win_d;      // previous SYNC_LEN-1 bits; current bit completes the window
  logic [PW-1:0]       pos_q, pos_d;
  logic [GW-1:0]       good_q, good_d;
  logic [MW-1:0]       miss_q, miss_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_W-1:0]   deser_q, deser_d;

  // Registered outputs
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                locked_q;
  logic                sync_pulse_q;
  logic                frame_err_q;
  logic                overflow_q;

  // Combinational helpers
  logic [SYNC_LEN-1:0] window_s;
  logic                match_s;
  logic                word_done_s;
  logic [DATA_W-1:0]   word_s;
  logic                sync_hit_s;
  logic                sync_bad_s;

  assign window_s = {win_q, in};
  assign match_s  = (window_s == SYNC_PATTERN);
  assign word_s   = {deser_q[DATA_W-2:0], in};

  // Next-state logic: FSM, frame position, lock/miss counters and deserialiser
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    pos_d       = pos_q;
    good_d      = good_q;
    miss_d      = miss_q;
    bit_d       = bit_q;
    deser_d     = deser_q;
    word_done_s = 1'b0;
    sync_hit_s  = 1'b0;
    sync_bad_s  = 1'b0;
    if (in_valid) begin
      win_d = window_s[SYNC_LEN-2:0];
      case (state_q)
        ST_HUNT: begin
          if (match_s) begin
            pos_d  = {PW{1'b0}};
            good_d = GOOD_ONE;
            bit_d  = {BW{1'b0}};
            miss_d = {MW{1'b0}};
            if (LOCK_LAST == {GW{1'b0}}) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_VERIFY;
            end
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_VERIFY: begin
          if (pos_q == CHECK_POS) begin
            pos_d = {PW{1'b0}};
            if (match_s) begin
              sync_hit_s = 1'b1;
              good_d     = good_q + 1'b1;
              if (good_q == LOCK_LAST) begin
                state_d = ST_LOCKED;
                miss_d  = {MW{1'b0}};
                bit_d   = {BW{1'b0}};
                deser_d = {DATA_W{1'b0}};
              end else begin
                state_d = ST_VERIFY;
              end
            end else begin
              sync_bad_s = 1'b1;
              state_d    = ST_HUNT;
              good_d     = {GW{1'b0}};
            end
          end else begin
            // Payload bits are skipped while the lock is still unconfirmed
            pos_d = pos_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (pos_q == CHECK_POS) begin
            pos_d = {PW{1'b0}};
            bit_d = {BW{1'b0}};
            if (match_s) begin
              sync_hit_s = 1'b1;
              miss_d     = {MW{1'b0}};
            end else begin
              sync_bad_s = 1'b1;
              if (miss_q == MISS_LAST) begin
                // Too many consecutive misses: give up and drop any partial word
                state_d = ST_HUNT;
                miss_d  = {MW{1'b0}};
                good_d  = {GW{1'b0}};
                deser_d = {DATA_W{1'b0}};
              end else begin
                // Flywheel: keep the frame timing and keep delivering payload
                miss_d = miss_q + 1'b1;
              end
            end
          end else begin
            pos_d = pos_q + 1'b1;
            if (pos_q < PAYLOAD_END) begin
              deser_d = word_s;
              if (bit_q == BIT_LAST) begin
                word_done_s = 1'b1;
                bit_d       = {BW{1'b0}};
              end else begin
                bit_d = bit_q + 1'b1;
              end
            end else begin
              // Sync bits are only examined at the check point
              bit_d = bit_q;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
          pos_d   = {PW{1'b0}};
        end
      endcase
    end else begin
      // No valid bit: everything holds
      state_d = state_q;
    end
  end

  // Core state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
      win_q   <= {(SYNC_LEN-1){1'b0}};
      pos_q   <= {PW{1'b0}};
      good_q  <= {GW{1'b0}};
      miss_q  <= {MW{1'b0}};
      bit_q   <= {BW{1'b0}};
      deser_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      pos_q   <= pos_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      bit_q   <= bit_d;
      deser_q <= deser_d;
    end
  end

  // Lock flag and one-cycle sync status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q     <= 1'b0;
      sync_pulse_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      locked_q     <= (state_d == ST_LOCKED);
      sync_pulse_q <= sync_hit_s;
      frame_err_q  <= sync_bad_s;
    end
  end

  // Single-entry holding register with valid/ready handshake and overflow pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (word_done_s) begin
        if (!out_valid_q || out_ready) begin
          out_data_q  <= word_s;
          out_valid_q <= 1'b1;
        end else begin
          // Consumer stalled: keep the held word, drop the new one
          overflow_q <= 1'b1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= out_valid_q;
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign locked     = locked_q;
  assign sync_pulse = sync_pulse_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

`ifdef FSYNC_STATS_EN
  logic        frame_hit_s;
  logic        slip_s;
  logic [15:0] frame_cnt_q;
  logic [7:0]  slip_cnt_q;

  assign frame_hit_s = sync_hit_s && (state_q == ST_LOCKED);
  assign slip_s      = (state_q == ST_LOCKED) && (state_d == ST_HUNT);

  // Statistics: wrapping good-frame count and saturating lock-loss count
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
      slip_cnt_q  <= 8'd0;
    end else begin
      if (frame_hit_s) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end else begin
        frame_cnt_q <= frame_cnt_q;
      end
      if (slip_s && (slip_cnt_q != 8'hFF)) begin
        slip_cnt_q <= slip_cnt_q + 8'd1;
      end else begin
        slip_cnt_q <= slip_cnt_q;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign slip_cnt  = slip_cnt_q;
`endif

endmodule
